// File: rtl/stub_app_ctrl.sv
// stub_app_ctrl: sequences a CGRA-stub application run. Issues delayed
// per-port start pulses, counts valid words per port, and reports per-port
// completion, global completion, timeout and overrun.
module stub_app_ctrl #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned DLY_WIDTH = 8,
  parameter int unsigned TO_WIDTH  = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           app_start,
  input  logic [NUM_PORTS-1:0]           port_en,
  input  logic [NUM_PORTS*CNT_WIDTH-1:0] num_words,
  input  logic [NUM_PORTS*DLY_WIDTH-1:0] start_delay,
  input  logic [TO_WIDTH-1:0]            timeout_limit,
  input  logic [NUM_PORTS-1:0]           port_valid,
  output logic [NUM_PORTS-1:0]           port_start,
  output logic [NUM_PORTS-1:0]           port_done,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout,
  output logic                           overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  localparam logic [TO_WIDTH-1:0]  CYC_ONE = TO_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                         state_q, state_d;
  logic [TO_WIDTH-1:0]            cycle_cnt_q, cycle_cnt_d;
  logic [TO_WIDTH-1:0]            tlim_q, tlim_d;
  logic [NUM_PORTS-1:0]           en_q, en_d;
  logic [NUM_PORTS-1:0]           started_q, started_d;
  logic [NUM_PORTS-1:0]           port_done_q, port_done_d;
  logic [NUM_PORTS*CNT_WIDTH-1:0] nwords_q, nwords_d;
  logic [NUM_PORTS*CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [NUM_PORTS*DLY_WIDTH-1:0] dly_q, dly_d;
  logic                           overrun_q, overrun_d;

  logic                 all_done;
  logic                 to_hit;
  logic [NUM_PORTS-1:0] start_hit;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // Run-status decode from registered state: start pulses, completion, timeout
  always_comb begin
    all_done  = &(port_done_q | ~en_q);
    start_hit = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      start_hit[i] = (state_q == S_RUN) && en_q[i] &&
                     (cycle_cnt_q == TO_WIDTH'(dly_q[i*DLY_WIDTH +: DLY_WIDTH]));
    end
    // completion takes priority over a coincident timeout
    to_hit = (state_q == S_RUN) && (tlim_q != '0) &&
             (cycle_cnt_q == tlim_q) && !all_done;
  end

  // Next-state logic: config latch, per-port counting, run sequencing
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    tlim_d      = tlim_q;
    en_d        = en_q;
    started_d   = started_q;
    port_done_d = port_done_q;
    nwords_d    = nwords_q;
    word_cnt_d  = word_cnt_q;
    dly_d       = dly_q;
    overrun_d   = overrun_q;
    cnt_inc     = '0;

    case (state_q)
      S_IDLE: begin
        if (app_start) begin
          en_d        = port_en;
          nwords_d    = num_words;
          dly_d       = start_delay;
          tlim_d      = timeout_limit;
          started_d   = '0;
          port_done_d = '0;
          word_cnt_d  = '0;
          overrun_d   = 1'b0;
          cycle_cnt_d = '0;
          state_d     = S_RUN;
        end
      end
      default: begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          if (port_valid[i]) begin
            if (!en_q[i] || !started_q[i] || port_done_q[i]) begin
              overrun_d = 1'b1;
            end else begin
              cnt_inc = word_cnt_q[i*CNT_WIDTH +: CNT_WIDTH] + CNT_ONE;
              word_cnt_d[i*CNT_WIDTH +: CNT_WIDTH] = cnt_inc;
              if (cnt_inc == nwords_q[i*CNT_WIDTH +: CNT_WIDTH]) begin
                port_done_d[i] = 1'b1;
              end
            end
          end
          if (start_hit[i]) begin
            started_d[i] = 1'b1;
            if (nwords_q[i*CNT_WIDTH +: CNT_WIDTH] == '0) begin
              port_done_d[i] = 1'b1;
            end
          end
        end

        if (state_q == S_FIN) begin
          state_d = S_IDLE;
        end else if (all_done) begin
          state_d = S_FIN;
        end else if (to_hit) begin
          state_d = S_IDLE;
        end else if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + CYC_ONE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cycle_cnt_q <= '0;
      tlim_q      <= '0;
      en_q        <= '0;
      started_q   <= '0;
      port_done_q <= '0;
      nwords_q    <= '0;
      word_cnt_q  <= '0;
      dly_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      tlim_q      <= tlim_d;
      en_q        <= en_d;
      started_q   <= started_d;
      port_done_q <= port_done_d;
      nwords_q    <= nwords_d;
      word_cnt_q  <= word_cnt_d;
      dly_q       <= dly_d;
      overrun_q   <= overrun_d;
    end
  end

  assign port_start = start_hit;
  assign port_done  = port_done_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);
  assign timeout    = to_hit;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_stub_app_ctrl.sv
// Testbench for stub_app_ctrl: directed scenarios with literal expectations
// plus randomized runs, all checked each cycle against a behavioural model.
module tb_stub_app_ctrl;
  localparam int NP = 4;
  localparam int CW = 16;
  localparam int DW = 8;
  localparam int TW = 24;
  localparam int CYC_MAX = (1 << TW) - 1;

  logic            clk = 1'b0;
  logic            reset, app_start;
  logic [NP-1:0]   port_en, port_valid;
  logic [NP*CW-1:0] num_words;
  logic [NP*DW-1:0] start_delay;
  logic [TW-1:0]   timeout_limit;
  logic [NP-1:0]   port_start, port_done;
  logic            busy, done, timeout, overrun;

  always #5 clk = ~clk;

  stub_app_ctrl #(.NUM_PORTS(NP), .CNT_WIDTH(CW), .DLY_WIDTH(DW), .TO_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .app_start(app_start), .port_en(port_en),
    .num_words(num_words), .start_delay(start_delay), .timeout_limit(timeout_limit),
    .port_valid(port_valid), .port_start(port_start), .port_done(port_done),
    .busy(busy), .done(done), .timeout(timeout), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model of the run
  bit m_run, m_fin, m_ovr;
  int m_cyc, m_tlim;
  bit m_en[NP], m_started[NP], m_pdone[NP];
  int m_nw[NP], m_dly[NP], m_cnt[NP];
  bit [NP-1:0] e_start;
  bit e_all, e_timeout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_outputs();
    e_all = 1'b1;
    for (int i = 0; i < NP; i++) begin
      e_start[i] = m_run && m_en[i] && (m_cyc == m_dly[i]);
      if (m_en[i] && !m_pdone[i]) e_all = 1'b0;
    end
    e_timeout = m_run && (m_tlim != 0) && (m_cyc == m_tlim) && !e_all;
  endfunction

  task automatic model_advance();
    model_outputs();
    if (reset) begin
      m_run = 0; m_fin = 0; m_ovr = 0; m_cyc = 0; m_tlim = 0;
      for (int i = 0; i < NP; i++) begin
        m_en[i] = 0; m_started[i] = 0; m_pdone[i] = 0; m_nw[i] = 0; m_dly[i] = 0; m_cnt[i] = 0;
      end
    end else if (!m_run && !m_fin) begin
      if (app_start) begin
        m_run = 1; m_cyc = 0; m_ovr = 0; m_tlim = int'(timeout_limit);
        for (int i = 0; i < NP; i++) begin
          m_en[i] = port_en[i];
          m_nw[i] = int'(num_words[i*CW +: CW]);
          m_dly[i] = int'(start_delay[i*DW +: DW]);
          m_started[i] = 0; m_pdone[i] = 0; m_cnt[i] = 0;
        end
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (port_valid[i]) begin
          if (!m_en[i] || !m_started[i] || m_pdone[i]) m_ovr = 1;
          else begin
            m_cnt[i]++;
            if (m_cnt[i] == m_nw[i]) m_pdone[i] = 1;
          end
        end
        if (e_start[i]) begin
          m_started[i] = 1;
          if (m_nw[i] == 0) m_pdone[i] = 1;
        end
      end
      if (m_fin) m_fin = 0;
      else if (e_all) begin m_run = 0; m_fin = 1; end
      else if (e_timeout) m_run = 0;
      else if (m_cyc < CYC_MAX) m_cyc++;
    end
  endtask

  task automatic compare_all();
    bit [NP-1:0] e_pd;
    model_outputs();
    for (int i = 0; i < NP; i++) e_pd[i] = m_pdone[i];
    chk("port_start", port_start, e_start);
    chk("port_done", port_done, e_pd);
    chk("busy", busy, m_run || m_fin);
    chk("done", done, m_fin);
    chk("timeout", timeout, e_timeout);
    chk("overrun", overrun, m_ovr);
  endtask

  // one clock: model consumes current inputs, DUT samples them, then compare
  task automatic tick();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_port(input int i, input int nw, input int dly);
    num_words[i*CW +: CW] = CW'(nw);
    start_delay[i*DW +: DW] = DW'(dly);
  endtask

  task automatic start_run();
    app_start = 1'b1;
    tick();
    app_start = 1'b0;
  endtask

  // stub ports: emit valid words after start, plus occasional stray valids
  task automatic stub_drive(input bit noisy);
    for (int i = 0; i < NP; i++) begin
      port_valid[i] = ((m_run || m_fin) && m_started[i] && !m_pdone[i] && ($urandom_range(1, 0) == 1)) ||
                      (noisy && ($urandom_range(39, 0) == 0));
    end
  endtask

  initial begin
    int first[NP];
    int cnt, ndone;
    reset = 1; app_start = 0; port_en = '0; num_words = '0; start_delay = '0;
    timeout_limit = '0; port_valid = '0;
    @(negedge clk);
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_pdone", port_done, 0);
    reset = 0;
    tick();

    // no enabled ports: done two cycles after app_start
    port_en = 4'b0000;
    start_run();
    chk("en0_busy", busy, 1);
    chk("en0_nodone", done, 0);
    tick(); chk("en0_done", done, 1);
    tick(); chk("en0_idle", busy, 0);

    // single port, 5 words, delay 0
    port_en = 4'b0001; set_port(0, 5, 0); timeout_limit = '0;
    start_run();
    chk("sp_start", port_start, 4'b0001);
    tick();
    port_valid = 4'b0001;
    repeat (5) tick();
    port_valid = '0;
    chk("sp_pdone", port_done, 4'b0001);
    chk("sp_busy", busy, 1);
    tick(); chk("sp_done", done, 1);
    tick(); chk("sp_idle", busy, 0);

    // staggered 4 ports
    port_en = 4'b1111;
    set_port(0, 2, 0); set_port(1, 4, 3); set_port(2, 1, 7); set_port(3, 3, 2);
    for (int i = 0; i < NP; i++) first[i] = -1;
    start_run();
    cnt = 0; ndone = 0;
    while (busy && cnt < 100) begin
      for (int i = 0; i < NP; i++) if (port_start[i] && first[i] < 0) first[i] = cnt;
      if (done) ndone++;
      stub_drive(0);
      tick();
      cnt++;
    end
    port_valid = '0;
    chk("stag_budget", cnt < 100, 1);
    chk("stag_s0", first[0], 0);
    chk("stag_s1", first[1], 3);
    chk("stag_s2", first[2], 7);
    chk("stag_s3", first[3], 2);
    chk("stag_ndone", ndone, 1);
    chk("stag_pdone", port_done, 4'b1111);

    // timeout at cycle_cnt == 50, port 1 silent
    port_en = 4'b0011; set_port(0, 10, 0); set_port(1, 10, 0); timeout_limit = 50;
    start_run();
    tick();
    port_valid = 4'b0001;
    repeat (10) tick();
    port_valid = '0;
    repeat (39) tick();
    chk("to_pulse", timeout, 1);
    chk("to_pdone", port_done, 4'b0001);
    chk("to_nodone", done, 0);
    tick();
    chk("to_idle", busy, 0);
    chk("to_once", timeout, 0);

    // completion on the timeout cycle: completion wins
    port_en = 4'b0001; set_port(0, 3, 0); timeout_limit = 4;
    start_run();
    tick();
    port_valid = 4'b0001;
    repeat (3) tick();
    port_valid = '0;
    chk("tie_noto", timeout, 0);
    tick(); chk("tie_done", done, 1);
    tick();

    // zero words on an enabled port
    port_en = 4'b0100; set_port(2, 0, 1); timeout_limit = '0;
    start_run();
    tick(); chk("nw0_start", port_start, 4'b0100);
    tick(); chk("nw0_pdone", port_done, 4'b0100);
    tick(); chk("nw0_done", done, 1);
    tick();

    // overrun on a disabled port; app_start during run is ignored
    port_en = 4'b0001; set_port(0, 1, 2);
    start_run();
    port_valid = 4'b0100;
    tick(); chk("ovr_set", overrun, 1);
    port_valid = '0;
    app_start = 1; set_port(0, 1, 0);
    tick(); chk("ign_start", port_start, 4'b0001);
    app_start = 0;
    tick();
    port_valid = 4'b0001;
    tick(); tick();
    port_valid = '0;
    chk("ovr_sticky", overrun, 1);
    tick(); chk("ovr_idle", overrun, 1);
    port_en = '0;
    start_run(); chk("ovr_clr", overrun, 0);
    tick(); tick();

    // reset in the middle of a run
    port_en = 4'b1111;
    for (int i = 0; i < NP; i++) set_port(i, 2, 9);
    start_run();
    repeat (5) tick();
    reset = 1;
    tick();
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_to", timeout, 0);
    chk("mrst_start", port_start, 0);
    reset = 0;
    tick();

    // randomized runs
    repeat (60) begin
      port_en = NP'($urandom_range(15, 0));
      for (int i = 0; i < NP; i++) set_port(i, $urandom_range(6, 0), $urandom_range(10, 0));
      timeout_limit = ($urandom_range(2, 0) == 0) ? TW'($urandom_range(30, 3)) : '0;
      start_run();
      cnt = 0;
      while ((m_run || m_fin) && cnt < 300) begin
        stub_drive(1);
        app_start = ($urandom_range(15, 0) == 0);
        reset = ($urandom_range(99, 0) == 0);
        tick();
        reset = 0; app_start = 0;
        cnt++;
      end
      chk("rnd_budget", cnt < 300, 1);
      repeat ($urandom_range(3, 0)) begin
        stub_drive(1);
        tick();
      end
      port_valid = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
